// File: rtl/sha2_msg_schedule.sv
// SHA-2 message-schedule expander: takes a 16-word block on a valid/ready stream
// and emits W[0..ROUNDS-1], one word per cycle, through a single output register.
module sha2_msg_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [6:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha2_msg_schedule: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 17 || ROUNDS > 128) begin : g_bad_rounds
    $error("sha2_msg_schedule: ROUNDS must be in 17..128");
  end

  // Rotation/shift amounts of the small sigma functions for the selected variant.
  localparam int S0_R1 = (WORD_W == 64) ? 1  : 7;
  localparam int S0_R2 = (WORD_W == 64) ? 8  : 18;
  localparam int S0_SH = (WORD_W == 64) ? 7  : 3;
  localparam int S1_R1 = (WORD_W == 64) ? 19 : 17;
  localparam int S1_R2 = (WORD_W == 64) ? 61 : 19;
  localparam int S1_SH = (WORD_W == 64) ? 6  : 10;

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction

  typedef enum logic {LOAD, GEN} state_t;

  state_t            state_reg, state_next;
  logic [6:0]        t_reg, t_next;
  logic [WORD_W-1:0] sched_mem [16];

  logic              free;
  logic              load_en;
  logic [WORD_W-1:0] new_word;
  logic [WORD_W-1:0] gen_word;
  logic [3:0]        slot, slot_m2, slot_m7, slot_m15;

  assign free = !out_valid || out_ready;

  // t-16 shares slot t, t-15 is slot t+1 (mod 16); slot t is read before it is overwritten.
  assign slot     = t_reg[3:0];
  assign slot_m2  = slot - 4'd2;
  assign slot_m7  = slot - 4'd7;
  assign slot_m15 = slot + 4'd1;

  assign gen_word = sigma1(sched_mem[slot_m2]) + sched_mem[slot_m7]
                  + sigma0(sched_mem[slot_m15]) + sched_mem[slot];

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    in_ready   = 1'b0;
    load_en    = 1'b0;
    new_word   = in_word;
    case (state_reg)
      LOAD: begin
        in_ready = free && !abort;
        load_en  = in_valid && free && !abort;
      end
      GEN: begin
        new_word = gen_word;
        load_en  = free && !abort;
      end
      default: ;
    endcase
    if (load_en) begin
      if (t_reg == LAST_T) begin
        t_next     = 7'd0;
        state_next = LOAD;
      end else begin
        t_next = t_reg + 7'd1;
        if (state_reg == LOAD && t_reg == 7'd15) state_next = GEN;
      end
    end
    if (abort) begin
      t_next     = 7'd0;
      state_next = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LOAD;
      t_reg     <= 7'd0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_idx   <= 7'd0;
      out_last  <= 1'b0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      // Abort drops the offered word even if the consumer took it this cycle.
      if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (load_en) begin
        out_valid <= 1'b1;
        out_word  <= new_word;
        out_idx   <= t_reg;
        out_last  <= (t_reg == LAST_T);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) sched_mem[slot] <= new_word;
  end

  assign busy = (t_reg != 7'd0) || out_valid;

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Self-checking bench for sha2_msg_schedule: SHA-256 and SHA-512 instances checked
// against an array-based schedule model under stalls, back-to-back blocks, abort and reset.
module tb_sha2_msg_schedule;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, abort, in_valid, out_ready;
  logic [63:0] in_word;

  logic        ir32, ov32, ol32, b32;
  logic [31:0] ow32;
  logic [6:0]  oi32;
  logic        ir64, ov64, ol64, b64;
  logic [63:0] ow64;
  logic [6:0]  oi64;

  sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(ir32),
    .in_word(in_word[31:0]), .out_valid(ov32), .out_ready(out_ready), .out_word(ow32),
    .out_idx(oi32), .out_last(ol32), .busy(b32));

  sha2_msg_schedule #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(ir64),
    .in_word(in_word), .out_valid(ov64), .out_ready(out_ready), .out_word(ow64),
    .out_idx(oi64), .out_last(ol64), .busy(b64));

  int checks = 0;
  int failures = 0;
  bit sel64 = 1'b0;

  logic        o_valid, o_last, o_busy, o_ready;
  logic [63:0] o_word;
  logic [6:0]  o_idx;
  always_comb begin
    o_valid = sel64 ? ov64 : ov32;
    o_last  = sel64 ? ol64 : ol32;
    o_busy  = sel64 ? b64  : b32;
    o_ready = sel64 ? ir64 : ir32;
    o_word  = sel64 ? ow64 : {32'd0, ow32};
    o_idx   = sel64 ? oi64 : oi32;
  end

  logic [63:0] m_blk [16];
  logic [63:0] ref_w [128];
  logic [63:0] got   [128];
  logic [63:0] in_q[$];
  logic [63:0] exp_q[$];
  int          expi_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] msk(input int w);
    return (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & msk(w);
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
    return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
    return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction

  // Straight textbook expansion over a full-length array.
  task automatic add_block(input bit abc, input int w, input int r);
    for (int i = 0; i < 16; i++) m_blk[i] = abc ? 64'd0 : {$urandom, $urandom};
    if (abc) begin
      m_blk[0]  = (w == 32) ? 64'h6162_6380 : 64'h6162_6380_0000_0000;
      m_blk[15] = 64'h18;
    end
    for (int i = 0; i < 16; i++) ref_w[i] = m_blk[i] & msk(w);
    for (int t = 16; t < r; t++)
      ref_w[t] = (sig1(ref_w[t-2], w) + ref_w[t-7] + sig0(ref_w[t-15], w) + ref_w[t-16]) & msk(w);
    for (int i = 0; i < 16; i++) in_q.push_back(ref_w[i]);
    for (int t = 0; t < r; t++) begin
      exp_q.push_back(ref_w[t]);
      expi_q.push_back(t);
    end
  endtask

  task automatic run(input bit s64, input int nblk, input bit abc, input int stall_a,
                     input int stall_b, input int abort_at, input int rst_at, input bit gap_chk);
    int w, r, stall_cnt, prev_cyc, xfers;
    bit done_a, done_b, evt_done, have_prev, finished, fresh;
    logic [63:0] held_word;
    logic [6:0]  held_idx;
    sel64 = s64;
    w = s64 ? 64 : 32;
    r = s64 ? 80 : 64;
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    in_q.delete(); exp_q.delete(); expi_q.delete();
    for (int i = 0; i < 128; i++) got[i] = 64'hDEAD;
    for (int b = 0; b < nblk; b++) add_block(abc, w, r);
    stall_cnt = 0; done_a = 0; done_b = 0; evt_done = 0; have_prev = 0;
    finished = 0; fresh = 0; prev_cyc = 0; xfers = 0;
    held_word = '0; held_idx = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_q.size() == 0) begin
        in_valid = 1'b0;
        #1;
        chk("end_out_valid", o_valid, 0);
        chk("end_busy", o_busy, 0);
        finished = 1;
        break;
      end
      if (abort_at >= 0 && !evt_done && o_valid && o_idx == 7'(abort_at)) begin
        evt_done = 1; abort = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_out_valid", o_valid, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_in_ready", o_ready, 1);
        in_q.delete(); exp_q.delete(); expi_q.delete();
        add_block(0, w, r);
        $display("abort at idx %0d, fresh block queued", abort_at);
        continue;
      end
      if (rst_at >= 0 && !evt_done && o_valid && o_idx == 7'(rst_at)) begin
        evt_done = 1; rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", o_valid, 0);
        chk("rst_out_word", o_word, 0);
        chk("rst_out_idx", o_idx, 0);
        chk("rst_out_last", o_last, 0);
        chk("rst_busy", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", o_ready, 1);
        in_q.delete(); exp_q.delete(); expi_q.delete();
        add_block(0, w, r);
        $display("reset at idx %0d, fresh block queued", rst_at);
        continue;
      end
      fresh = 0;
      if (stall_cnt == 0 && o_valid &&
          ((o_idx == 7'(stall_a) && !done_a) || (o_idx == 7'(stall_b) && !done_b))) begin
        if (o_idx == 7'(stall_a)) done_a = 1; else done_b = 1;
        stall_cnt = 5; held_word = o_word; held_idx = o_idx; fresh = 1;
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (in_q.size() > 0);
      in_word  = in_valid ? in_q[0] : {$urandom, $urandom};
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", o_ready, 0);
        if (!fresh) begin
          chk("stall_word", o_word, held_word);
          chk("stall_idx", o_idx, held_idx);
        end
      end
      if (o_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", o_valid, 0);
        end else begin
          chk("word", o_word, exp_q[0]);
          chk("idx", o_idx, 64'(expi_q[0]));
          chk("last", o_last, (expi_q[0] == r - 1) ? 64'd1 : 64'd0);
          got[expi_q[0]] = o_word;
          $display("w%0d xfer idx=%0d word=%h last=%0b", w, o_idx, o_word, o_last);
          if (gap_chk && have_prev) chk("gap", 64'(cyc - prev_cyc), 1);
          prev_cyc = cyc; have_prev = 1; xfers++;
          void'(exp_q.pop_front());
          void'(expi_q.pop_front());
        end
      end
      if (in_valid && o_ready) void'(in_q.pop_front());
    end
    chk("completed", finished, 1);
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid32", ov32, 0);
    chk("reset_out_word32", ow32, 0);
    chk("reset_out_idx32", oi32, 0);
    chk("reset_out_last32", ol32, 0);
    chk("reset_busy32", b32, 0);
    chk("reset_out_valid64", ov64, 0);
    chk("reset_busy64", b64, 0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready32", ir32, 1);
    chk("reset_in_ready64", ir64, 1);

    run(0, 1, 1, -1, -1, -1, -1, 1);
    chk("abc32_w16", got[16], 64'h6162_6380);
    chk("abc32_w17", got[17], 64'h000F_0000);

    run(1, 1, 1, -1, -1, -1, -1, 1);
    chk("abc64_w16", got[16], 64'h6162_6380_0000_0000);
    chk("abc64_w17", got[17], 64'h0003_0000_0000_00C0);

    run(0, 1, 0, 3, 20, -1, -1, 0);
    run(0, 2, 0, -1, -1, -1, -1, 1);
    run(0, 1, 0, -1, -1, 30, -1, 0);
    run(0, 1, 0, -1, -1, -1, 10, 0);
    run(1, 1, 0, 5, 40, -1, -1, 0);
    run(1, 2, 0, -1, -1, -1, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha2_msg_schedule.md
# sha2_msg_schedule

Parametrised SHA-2 message-schedule expander: accepts one 16-word message block over a valid/ready input stream and emits the full schedule W[0..ROUNDS-1] over a valid/ready output stream, one word per cycle. WORD_W selects SHA-256 (32-bit) or SHA-512 (64-bit) small-sigma functions. The block sits between the padding/block-assembly stage and the compression round engine, and replaces per-round schedule logic inside the round engine.

## Interface
- WORD_W, 32, word width; 32 selects SHA-256 sigma constants, 64 selects SHA-512; any other value is an elaboration error
- ROUNDS, 64, schedule length per block; legal 17..128 (64 for SHA-256, 80 for SHA-512)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- abort  in  1  synchronous flush of the current block
- in_valid  in  1  in_word valid
- in_ready  out  1  block accepts in_word this cycle
- in_word  in  WORD_W  message word, W[0] first, big-endian word order as delivered
- out_valid  out  1  out_word valid
- out_ready  in  1  downstream accepts out_word
- out_word  out  WORD_W  schedule word W[out_idx]
- out_idx  out  7  index t of out_word
- out_last  out  1  high with out_idx = ROUNDS-1
- busy  out  1  block in progress or output register occupied

## Operation
- Storage: 16-entry circular buffer of WORD_W words, slot = t mod 16; 7-bit counter t; one output register (out_word, out_idx, out_last, out_valid).
- States: LOAD (t < 16, words come from input), GEN (16 ≤ t < ROUNDS, words computed).
- Output register free: !out_valid | out_ready.
- LOAD: in_ready = free & !abort. On in_valid & in_ready: buf[t]←in_word, output register←(in_word, t, t==ROUNDS-1), t←t+1; at t=15 go to GEN.
- GEN: in_ready = 0. When free & !abort: W = σ1(buf[t-2]) + buf[t-7] + σ0(buf[t-15]) + buf[t-16], all indices mod 16, sum mod 2^WORD_W; buf[t mod 16]←W, output register←(W, t, t==ROUNDS-1), t←t+1. After t=ROUNDS-1 loaded: t←0, state LOAD.
- WORD_W=32: σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
- WORD_W=64: σ0 = ROTR1^ROTR8^SHR7; σ1 = ROTR19^ROTR61^SHR6.
- Output register cleared (out_valid←0) when out_ready & out_valid and no new word loads that cycle.
- busy = (t != 0) | out_valid.
- abort: next edge t←0, state LOAD, out_valid←0, out_last←0; buffer contents don't-care. Abort wins over simultaneous in or out handshakes; the word offered on out_word that cycle counts as not transferred.

## Timing
- Reset values: out_valid 0, out_word 0, out_idx 0, out_last 0, busy 0, t 0, state LOAD; in_ready 1 after reset release, with abort low.
- Latency: in_word accepted at edge k appears on out_word after edge k.
- Throughput: 1 word/cycle with out_ready held high; a block occupies ROUNDS consecutive output cycles.
- Back-to-back blocks: next block's W[0] is accepted in the same cycle W[ROUNDS-1] is consumed; zero bubbles.
- Backpressure: with out_ready low, out_word/out_idx/out_last hold stable, t does not advance, no index is skipped or repeated.
- GEN dependency on W[t-2] is satisfied from the buffer with no stall cycle.
- Reset mid-block: all outputs return to reset values immediately; the partial block is lost.

## Test plan
- SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> 64 words, out_idx 0..63 contiguous, W16=0x61626380, W17=0x000F0000, out_last only at idx 63, busy low after last transfer.
- WORD_W=64, ROUNDS=80, W0=0x6162638000000000, W15=0x18, rest 0 -> W16=0x6162638000000000, W17=0x00030000000000C0, out_last at idx 79.
- Backpressure: out_ready low for 5 cycles at idx 3 (LOAD) and at idx 20 (GEN) -> in_ready low during LOAD stall, out_word stable, sequence matches the unstalled reference model.
- Two blocks streamed back-to-back -> second block's idx 0 appears in the cycle after idx 63 of the first; no gap; both schedules correct.
- abort asserted at idx 30 with out_valid high -> next cycle out_valid=0, busy=0, in_ready=1; a fresh block then produces a correct schedule.
- rst_n pulsed low at idx 10 -> outputs at reset values asynchronously; recovery as in the abort scenario.
